// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped UART transmitter with push buffer
// Define UART_TX_FIFO_EN for a 4-entry FIFO; otherwise a single holding register is used.
module uart_tx_mmio #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [31:0] TX_ADDR      = 32'h0000_03f4,
    parameter logic [31:0] STAT_ADDR    = 32'h0000_03f0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] rw_addr,
    input  logic [31:0] w_data,
    input  logic        w_en,
    output logic        hit,
    output logic [31:0] r_data,
    output logic        tx
);
`ifdef UART_TX_FIFO_EN
    localparam logic [2:0] DEPTH = 3'd4;
`else
    localparam logic [2:0] DEPTH = 3'd1;
`endif
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic [2:0]  count_q, count_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  mem_q [4];
    logic [7:0]  mem_d [4];

    logic pop, push_req, push_ok, ovf_clr, baud_done;
    logic unused_wdata;

    assign unused_wdata = ^{w_data[31:8], w_data[2:0]};

    assign push_req  = w_en && (rw_addr == TX_ADDR);
    assign ovf_clr   = w_en && (rw_addr == STAT_ADDR) && w_data[3];
    assign baud_done = (baud_q == BAUD_LAST);

    assign hit    = (rw_addr == TX_ADDR) || (rw_addr == STAT_ADDR);
    assign r_data = (rw_addr == STAT_ADDR) ?
                    {28'b0, ovf_q, count_q == 3'd0, count_q == DEPTH, state_q != IDLE} : 32'b0;
    assign tx     = tx_q;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return ({1'b0, p} == DEPTH - 3'd1) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = 16'd0;
                if (count_q != 3'd0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_done) begin
                    state_d = DATA;
                    baud_d  = 16'd0;
                end
            end
            DATA: begin
                tx_d = shift_q[bit_q];
                if (baud_done) begin
                    baud_d = 16'd0;
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (baud_done) begin
                    state_d = IDLE;
                    baud_d  = 16'd0;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = 16'd0;
            end
        endcase
    end

    // A full buffer still accepts a push when the head leaves on the same edge.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        push_ok  = push_req && ((count_q < DEPTH) || pop);
        if (push_ok) begin
            mem_d[wr_ptr_q] = w_data[7:0];
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop) rd_ptr_d = next_ptr(rd_ptr_q);
        count_d = count_q + {2'b0, push_ok} - {2'b0, pop};
        ovf_d   = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (push_req && !push_ok) ovf_d = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            baud_q   <= 16'd0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            count_q  <= 3'd0;
            rd_ptr_q <= 2'd0;
            wr_ptr_q <= 2'd0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule
